// File: rtl/exp7_exibe_sequencia.sv
// Sequence-display unit: walks pattern memory from address 0 up to rodada and lights each entry on the LEDs.
// Optional macro EXIBE_ABORTA_EN adds a synchronous 'aborta' input that cancels a display in progress.
module exp7_exibe_sequencia #(
    parameter int ON_CYCLES  = 1000,
    parameter int OFF_CYCLES = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
    input  logic [3:0] mem_dado,
`ifdef EXIBE_ABORTA_EN
    input  logic       aborta,
`endif
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam logic [15:0] ON_LAST  = 16'(ON_CYCLES - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_CYCLES - 1);

    estado_t     estado;
    estado_t     proximo_estado;
    logic [15:0] timer;
    logic [3:0]  rodada_reg;
    logic        abortar;

`ifdef EXIBE_ABORTA_EN
    assign abortar = aborta;
`else
    assign abortar = 1'b0;
`endif

    // Next-state logic; abort overrides everything, including a start request in ocioso.
    always_comb begin
        proximo_estado = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    proximo_estado = CARREGA;
                end else begin
                    proximo_estado = OCIOSO;
                end
            end
            CARREGA: proximo_estado = ACENDE;
            ACENDE: begin
                if (timer == ON_LAST) begin
                    proximo_estado = APAGA;
                end else begin
                    proximo_estado = ACENDE;
                end
            end
            APAGA: begin
                if (timer != OFF_LAST) begin
                    proximo_estado = APAGA;
                end else if (mem_endereco == rodada_reg) begin
                    proximo_estado = FIM;
                end else begin
                    proximo_estado = PROXIMO;
                end
            end
            PROXIMO: proximo_estado = CARREGA;
            FIM:     proximo_estado = OCIOSO;
            default: proximo_estado = OCIOSO;
        endcase
        if (abortar) begin
            proximo_estado = OCIOSO;
        end else begin
            proximo_estado = proximo_estado;
        end
    end

    // State, timer and registered outputs; outputs are derived from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            timer        <= 16'd0;
            rodada_reg   <= 4'd0;
            mem_endereco <= 4'd0;
            leds         <= 4'd0;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            estado  <= proximo_estado;
            timer   <= (proximo_estado != estado) ? 16'd0 : timer + 16'd1;
            ocupado <= (proximo_estado == CARREGA) || (proximo_estado == ACENDE) ||
                       (proximo_estado == APAGA)   || (proximo_estado == PROXIMO);
            pronto  <= (proximo_estado == FIM);

            // ACENDE is only entered from CARREGA, when the memory data is valid.
            if (proximo_estado == ACENDE) begin
                if (estado != ACENDE) begin
                    leds <= mem_dado;
                end
            end else begin
                leds <= 4'd0;
            end

            if (estado == OCIOSO && proximo_estado == CARREGA) begin
                rodada_reg   <= rodada;
                mem_endereco <= 4'd0;
            end else if (estado == PROXIMO && proximo_estado == CARREGA) begin
                mem_endereco <= mem_endereco + 4'd1;
            end
        end
    end

    // Debug code for the 7-segment display; unknown encodings show as F.
    always_comb begin
        case (estado)
            OCIOSO:  db_estado = 4'h0;
            CARREGA: db_estado = 4'h1;
            ACENDE:  db_estado = 4'h2;
            APAGA:   db_estado = 4'h3;
            PROXIMO: db_estado = 4'h4;
            FIM:     db_estado = 4'h5;
            default: db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_exp7_exibe_sequencia.sv
// Scoreboard bench for exp7_exibe_sequencia: stimulus queues expected LED changes and pronto pulses,
// a monitor pops and compares them as the DUT produces them.
module tb_exp7_exibe_sequencia;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = ON + OFF + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] rodada = 4'd0;
    logic [3:0] mem_dado;
    logic       aborta = 1'b0;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    exp7_exibe_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .rodada       (rodada),
        .mem_dado     (mem_dado),
`ifdef EXIBE_ABORTA_EN
        .aborta       (aborta),
`endif
        .mem_endereco (mem_endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] pat(input int a);
        logic [3:0] one;
        one = 4'b0001;
        return one << (a % 4);
    endfunction

    // Combinational pattern memory: data valid during the cycle after the address changes.
    assign mem_dado = pat(int'(mem_endereco));

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } ev_t;

    ev_t leds_q[$];
    int  pronto_q[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  s_edge = 0;
    logic [3:0] prev_leds = 4'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every LED change and every pronto cycle must match the head of its queue.
    always @(negedge clock) begin
        if (!reset) begin
            if (leds !== prev_leds) begin
                n_tests++;
                if (leds_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL leds_unexpected: got %b at edge %0d, none expected", leds, cyc);
                end else begin
                    ev_t e;
                    e = leds_q.pop_front();
                    if (e.val !== leds || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL leds_event: got %b at edge %0d expected %b at edge %0d",
                                 leds, cyc, e.val, e.cyc);
                    end
                end
            end
            if (pronto) begin
                n_tests++;
                if (pronto_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pronto_unexpected: pulse at edge %0d, none expected", cyc);
                end else begin
                    int pc;
                    pc = pronto_q.pop_front();
                    if (pc != cyc) begin
                        n_fail++;
                        $display("FAIL pronto_event: got edge %0d expected edge %0d", cyc, pc);
                    end
                end
            end
        end
        prev_leds = leds;
    end

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    // Pulse iniciar; queue the first n_shown entries and optionally the pronto pulse.
    task automatic start(input logic [3:0] r, input int n_shown, input int n_total, input bit with_pronto);
        @(negedge clock);
        rodada  = r;
        iniciar = 1'b1;
        s_edge  = cyc + 1;
        for (int k = 0; k < n_shown; k++) begin
            leds_q.push_back('{s_edge + k * PER + 1, pat(k)});
            leds_q.push_back('{s_edge + k * PER + 1 + ON, 4'd0});
        end
        if (with_pronto) pronto_q.push_back(s_edge + n_total * PER - 1);
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_leds", 32'(leds), 32'd0);
        chk("reset_addr", 32'(mem_endereco), 32'd0);
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        chk("reset_pronto", 32'(pronto), 32'd0);
        chk("reset_db", 32'(db_estado), 32'd0);
        reset = 1'b0;

        // rodada=0: one entry, state walk checked through db_estado
        start(4'd0, 1, 1, 1'b1);
        chk("t1_ocupado_carrega", 32'(ocupado), 32'd1);
        chk("t1_db_carrega", 32'(db_estado), 32'd1);
        wait_edge(s_edge + 1);
        chk("t1_db_acende", 32'(db_estado), 32'd2);
        wait_edge(s_edge + 4);
        chk("t1_db_apaga", 32'(db_estado), 32'd3);
        wait_edge(s_edge + 6);
        chk("t1_db_fim", 32'(db_estado), 32'd5);
        chk("t1_ocupado_fim", 32'(ocupado), 32'd0);
        wait_edge(s_edge + 7);
        chk("t1_db_ocioso", 32'(db_estado), 32'd0);
        chk("t1_ocupado_ocioso", 32'(ocupado), 32'd0);

        // rodada=3: four entries, pronto after edge 27
        start(4'd3, 4, 4, 1'b1);
        wait_edge(s_edge + 6);
        chk("t2_db_proximo", 32'(db_estado), 32'd4);
        wait_edge(s_edge + 28);
        chk("t2_addr_end", 32'(mem_endereco), 32'd3);
        chk("t2_ocupado_end", 32'(ocupado), 32'd0);

        // iniciar re-pulsed in acende and rodada changed mid-display: still 3 entries
        start(4'd2, 3, 3, 1'b1);
        wait_edge(s_edge + 2);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        rodada  = 4'd5;
        wait_edge(s_edge + 30);
        chk("t3_addr_end", 32'(mem_endereco), 32'd2);
        chk("t3_ocupado_end", 32'(ocupado), 32'd0);

        // reset during the second apaga: outputs clear at once, no pronto
        start(4'd3, 2, 4, 1'b0);
        wait_edge(s_edge + 12);
        chk("t4_db_apaga", 32'(db_estado), 32'd3);
        reset = 1'b1;
        #1;
        chk("t4_rst_leds", 32'(leds), 32'd0);
        chk("t4_rst_addr", 32'(mem_endereco), 32'd0);
        chk("t4_rst_ocupado", 32'(ocupado), 32'd0);
        chk("t4_rst_db", 32'(db_estado), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        start(4'd1, 2, 2, 1'b1);
        wait_edge(s_edge + 2 * PER + 1);

        // rodada=15: sixteen entries, no address wrap, pronto after edge 111
        start(4'd15, 16, 16, 1'b1);
        wait_edge(s_edge + 111);
        chk("t5_addr_fim", 32'(mem_endereco), 32'd15);
        wait_edge(s_edge + 113);
        chk("t5_addr_end", 32'(mem_endereco), 32'd15);
        chk("t5_ocupado_end", 32'(ocupado), 32'd0);

`ifdef EXIBE_ABORTA_EN
        // aborta during the second acende: leds and ocupado drop on the next edge, no pronto
        start(4'd3, 1, 4, 1'b0);
        leds_q.push_back('{s_edge + PER + 1, pat(1)});
        leds_q.push_back('{s_edge + PER + 2, 4'd0});
        wait_edge(s_edge + PER + 1);
        aborta = 1'b1;
        @(negedge clock);
        aborta = 1'b0;
        chk("t6_abort_leds", 32'(leds), 32'd0);
        chk("t6_abort_ocupado", 32'(ocupado), 32'd0);
        chk("t6_abort_db", 32'(db_estado), 32'd0);
        wait_edge(s_edge + 4 * PER + 2);
`endif

        repeat (3) @(negedge clock);
        chk("leds_queue_empty", 32'(leds_q.size()), 32'd0);
        chk("pronto_queue_empty", 32'(pronto_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exp7_exibe_sequencia.md
# exp7_exibe_sequencia

Sequence-display unit for the memory game: on a start pulse from the game control unit it reads the stored color sequence from the synchronous pattern memory, address 0 up to the current round, and lights each entry on the 4 player LEDs for a fixed on-time followed by a fixed off-time. It is the output side of the game loop. It shows the sequence the player must reproduce, and the player-input control unit then takes over. It raises `pronto` for one cycle when the last entry has been shown.

## Interface
- `ON_CYCLES`, 1000, clock cycles each entry is lit (1..65535)
- `OFF_CYCLES`, 500, clock cycles of dark gap after each entry (1..65535)
- `clock` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-high
- `iniciar` in 1 start request, sampled only in `ocioso`
- `rodada` in 4 index of last entry to show (shows `rodada`+1 entries)
- `mem_dado` in 4 memory read data, valid one cycle after `mem_endereco` changes
- `mem_endereco` out 4 memory read address (registered)
- `leds` out 4 LED drive (registered)
- `ocupado` out 1 high while a display is in progress
- `pronto` out 1 one-cycle pulse at end of display
- `db_estado` out 4 current state code, for 7-seg debug

## Operation
- States and codes: `ocioso`=0, `carrega`=1, `acende`=2, `apaga`=3, `proximo`=4, `fim`=5. Any other value goes to `ocioso`, and `db_estado`=F for it.
- `ocioso`: if `iniciar`=1, latch `rodada` into `rodada_reg`, set `mem_endereco`=0 and go to `carrega`. Otherwise stay.
- `carrega`: 1 cycle, covering the memory read latency. On exit, load `leds` with `mem_dado`, clear the timer and go to `acende`.
- `acende`: hold `leds` for ON_CYCLES cycles. On the last one, clear `leds` and the timer and go to `apaga`.
- `apaga`: `leds`=0 for OFF_CYCLES cycles. On the last one, go to `fim` if `mem_endereco`==`rodada_reg`, else go to `proximo`.
- `proximo`: 1 cycle. Increment `mem_endereco`, go to `carrega`.
- `fim`: 1 cycle with `pronto`=1, then go to `ocioso`. `mem_endereco` holds its last value until the next start.
- `ocupado`=1 in `carrega`, `acende`, `apaga` and `proximo`. It is 0 in `ocioso` and `fim`.
- `iniciar` asserted outside `ocioso` is ignored, and a new display does not restart. A change on `rodada` after start has no effect on the current display.
- Timer is a 16-bit up-counter, cleared on every state entry. Address arithmetic is 4-bit. `rodada`=15 shows all 16 entries with no wrap.
- A `mem_dado` value of 0 is displayed as dark with no special handling.

## Timing
- Reset values: `leds`=0, `mem_endereco`=0, `ocupado`=0, `pronto`=0, `db_estado`=0, state=`ocioso`, timer=0.
- Reset asserted mid-display returns the unit to `ocioso` at once with all reset values and no `pronto` pulse.
- Cost is N=`rodada`+1 entries × (ON_CYCLES+OFF_CYCLES+2) cycles.
- `pronto` goes high after edge N·(ON_CYCLES+OFF_CYCLES+2)−1, counted from the edge that sampled `iniciar` (edge 0). It stays high one cycle.
- Entry k is lit on `leds` starting after edge k·(ON+OFF+2)+1, for exactly ON_CYCLES cycles.
- `iniciar` held high continuously restarts the unit on the cycle after `fim`, because `ocioso` samples it.

## Configuration
- `EXIBE_ABORTA_EN` defined adds input port `aborta` (1 bit, synchronous, active-high).
  - In any state except `ocioso`, `aborta`=1 takes the unit to `ocioso` on the next edge.
  - On that edge it clears `leds`, drops `ocupado` and produces no `pronto` pulse.
  - In `ocioso`, `aborta` has priority over `iniciar`.
- Undefined: no `aborta` port, and a display always runs to completion unless `reset` is asserted.

## Test plan
Bench settings: ON_CYCLES=3, OFF_CYCLES=2. Memory holds 0001, 0010, 0100, 1000, 0001, … at addresses 0, 1, 2, 3, 4, ….
- Reset, then `iniciar` pulse with `rodada`=0 → `leds`=0001 for cycles 2–4, `pronto` high after edge 6, then `ocioso` with `ocupado`=0.
- `rodada`=3 → `leds` shows 0001, 0010, 0100, 1000, each for 3 cycles with 2 dark cycles between, and `pronto` after edge 27.
- `iniciar` re-pulsed during `acende`, and `rodada` changed from 2 to 5 mid-display → exactly 3 entries shown, one `pronto` pulse.
- Reset asserted during the second `apaga` → all outputs 0 immediately, no `pronto`, and the next `iniciar` starts again from address 0.
- `rodada`=15 → 16 entries, `mem_endereco` ends at 15 with no wrap, `pronto` after edge 111.
- With `EXIBE_ABORTA_EN`: `aborta` pulse during the second `acende` of `rodada`=3 → `leds`=0 and `ocupado`=0 on the next edge, and `pronto` stays 0.
